// File: rtl/hex_display_scanner.sv
// Four-digit common-anode seven-segment scanner.
// The 16-bit word is latched once per frame so a scan never mixes two values.
// Each nibble is decoded to a hex glyph and the four digits are time-multiplexed,
// with an all-off gap at the start of every slot to suppress ghosting.
module hex_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_q;
  logic [15:0]   shadow;
  logic          wrap;
  logic          capture;

  logic [3:0]    nibble;
  logic          upper_zero;
  logic          lit;
  logic [6:0]    glyph;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    an_d;

  assign wrap      = (prescaler == P_LAST);
  assign capture   = wrap && (digit_q == 2'd3);
  assign digit_idx = digit_q;

  // Slot timer, digit pointer and frame-boundary capture of the display word.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      digit_q   <= 2'd0;
      shadow    <= 16'h0000;
    end else begin
      if (wrap) begin
        prescaler <= '0;
        digit_q   <= digit_q + 2'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      if (capture) begin
        shadow <= value;
      end
    end
  end

  // Pick the current nibble and whether it and all higher nibbles are zero.
  always_comb begin
    nibble     = shadow[3:0];
    upper_zero = 1'b0;
    case (digit_q)
      2'd3: begin
        nibble     = shadow[15:12];
        upper_zero = (shadow[15:12] == 4'h0);
      end
      2'd2: begin
        nibble     = shadow[11:8];
        upper_zero = (shadow[15:8] == 8'h00);
      end
      2'd1: begin
        nibble     = shadow[7:4];
        upper_zero = (shadow[15:4] == 12'h000);
      end
      default: begin
        nibble     = shadow[3:0];
        upper_zero = 1'b0;
      end
    endcase
  end

  // Hex glyph lookup, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  // Next output values: everything dark in the gap, anode stays on for blanked zeros.
  always_comb begin
    lit   = (prescaler >= P_BLANK);
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = (blank_lz && upper_zero) ? 7'h7F : glyph;
      dp_d  = ~dp_mask[digit_q];
    end
  end

  // Registered drivers so the pins change cleanly one cycle after the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_tick <= capture;
    end
  end

endmodule
